// File: rtl/nibble_compare_sequencer.sv
// Multi-cycle unsigned A/B magnitude compare, one 4-bit nibble per clock, MSB nibble first.
// Latency NIB+1 from start; data-dependent with NIBBLE_CMP_EARLY_EXIT_EN defined.
// No backpressure: start is taken only in IDLE, and a start seen while busy is dropped.
module nibble_compare_sequencer #(
   parameter int WIDTH = 16,
   localparam int NIB = WIDTH / 4,
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             A_greater_B,
   output logic             A_less_B,
   output logic             A_equal_B,
   output logic [IW-1:0]    nib_idx
);

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   localparam logic [IW-1:0] IDX_TOP = IW'(NIB - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   logic             decided_q, gt_q;
   logic [IW+1:0]    bit_lo;
   logic [3:0]       a_nib, b_nib;
   logic             take, early_exit, last_nib;
   logic             decided_nxt, gt_nxt;

   always_comb begin
      bit_lo = {nib_idx, 2'b00};
      a_nib  = a_q[bit_lo +: 4];
      b_nib  = b_q[bit_lo +: 4];
   end

   // Only the first differing nibble from the MSB may set the verdict.
   assign take        = (state == CMP) && !decided_q && (a_nib != b_nib);
   assign decided_nxt = decided_q | take;
   assign gt_nxt      = take ? (a_nib > b_nib) : gt_q;

`ifdef NIBBLE_CMP_EARLY_EXIT_EN
   assign early_exit = take;
`else
   assign early_exit = 1'b0;
`endif

   assign last_nib = (nib_idx == '0) || early_exit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CMP;
         CMP:     if (last_nib) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         CMP:     busy = 1'b1;
         DONE:    begin busy = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   // Flags load on the CMP->DONE edge so they are already valid while done is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q         <= '0;
         b_q         <= '0;
         decided_q   <= 1'b0;
         gt_q        <= 1'b0;
         nib_idx     <= IDX_TOP;
         A_greater_B <= 1'b0;
         A_less_B    <= 1'b0;
         A_equal_B   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q       <= A;
                  b_q       <= B;
                  nib_idx   <= IDX_TOP;
                  decided_q <= 1'b0;
                  gt_q      <= 1'b0;
               end
            end
            CMP: begin
               decided_q <= decided_nxt;
               gt_q      <= gt_nxt;
               if (last_nib) begin
                  A_greater_B <= gt_nxt;
                  A_less_B    <= decided_nxt & ~gt_nxt;
                  A_equal_B   <= ~decided_nxt;
               end else begin
                  nib_idx <= nib_idx - 1'b1;
               end
            end
            DONE: begin
               nib_idx <= IDX_TOP;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_compare_sequencer.sv
// Directed bench for nibble_compare_sequencer at WIDTH=16; honours NIBBLE_CMP_EARLY_EXIT_EN.
module tb_nibble_compare_sequencer;

`ifdef NIBBLE_CMP_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic        busy, done, A_greater_B, A_less_B, A_equal_B;
   logic [1:0]  nib_idx;

   int n_cmp  = 0;
   int n_fail = 0;

   nibble_compare_sequencer #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .A_greater_B(A_greater_B),
      .A_less_B(A_less_B), .A_equal_B(A_equal_B), .nib_idx(nib_idx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start is sampled at the next edge (cycle 0); returns during cycle 1.
   task automatic launch(input logic [15:0] a, input logic [15:0] b);
      A = a;
      B = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Observes cycles first..last; records the first done cycle and sanity of busy/flags/nib_idx.
   task automatic watch(input int first, input int last, output int dcyc, output int ndone,
                        output bit busy_ok, output bit held_ok, output bit idx_ok);
      logic [2:0] flags0;
      flags0  = {A_greater_B, A_less_B, A_equal_B};
      dcyc    = -1;
      ndone   = 0;
      busy_ok = 1'b1;
      held_ok = 1'b1;
      idx_ok  = 1'b1;
      for (int c = first; c <= last; c++) begin
         if (done === 1'b1) begin
            ndone++;
            if (dcyc < 0) dcyc = c;
         end
         if (busy !== ((dcyc < 0) || (c == dcyc))) busy_ok = 1'b0;
         if (dcyc < 0) begin
            if ({A_greater_B, A_less_B, A_equal_B} !== flags0) held_ok = 1'b0;
            if (c <= 4 && nib_idx !== 2'(4 - c)) idx_ok = 1'b0;
         end
         tick();
      end
   endtask

   task automatic check_result(input string name, input int dcyc, input int exp_cyc,
                               input logic [2:0] exp_flags);
      n_cmp++;
      if (dcyc !== exp_cyc) begin
         n_fail++;
         $display("FAIL %s done_cycle: got %0d want %0d", name, dcyc, exp_cyc);
      end
      n_cmp++;
      if ({A_greater_B, A_less_B, A_equal_B} !== exp_flags) begin
         n_fail++;
         $display("FAIL %s flags{gt,lt,eq}: got %b want %b", name,
                  {A_greater_B, A_less_B, A_equal_B}, exp_flags);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check_bit("reset busy", busy, 1'b0);
      check_bit("reset done", done, 1'b0);
      n_cmp++;
      if ({A_greater_B, A_less_B, A_equal_B} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset flags: got %b want 000", {A_greater_B, A_less_B, A_equal_B});
      end
      n_cmp++;
      if (nib_idx !== 2'd3) begin
         n_fail++;
         $display("FAIL reset nib_idx: got %0d want 3", nib_idx);
      end
   endtask

   task automatic test_equal();
      int d, nd;
      bit bok, hok, iok;
      launch(16'h1234, 16'h1234);
      watch(1, 8, d, nd, bok, hok, iok);
      check_result("equal", d, 5, 3'b001);
      check_bit("equal busy_profile", bok, 1'b1);
      check_bit("equal nib_idx_walk", iok, 1'b1);
      check_bit("equal single_done", nd == 1, 1'b1);
   endtask

   task automatic test_greater();
      int d, nd;
      bit bok, hok, iok;
      launch(16'h8000, 16'h7FFF);
      watch(1, 8, d, nd, bok, hok, iok);
      check_result("greater", d, EE ? 2 : 5, 3'b100);
      check_bit("greater busy_profile", bok, 1'b1);
      check_bit("greater held_prior", hok, 1'b1);
   endtask

   task automatic test_less_low_nibble();
      int d, nd;
      bit bok, hok, iok;
      launch(16'h00F0, 16'h00F1);
      watch(1, 8, d, nd, bok, hok, iok);
      check_result("less", d, 5, 3'b010);
      check_bit("less held_prior", hok, 1'b1);
      check_bit("less nib_idx_walk", iok, 1'b1);
   endtask

   task automatic test_start_while_busy();
      int d, nd;
      bit bok, hok, iok;
      launch(16'h0001, 16'h0002);
      tick();
      start = 1'b1;
      A = 16'hFFFF;
      B = 16'h0000;
      tick();
      start = 1'b0;
      A = 16'h0003;
      watch(3, 10, d, nd, bok, hok, iok);
      check_result("busy_start", d, 5, 3'b010);
      check_bit("busy_start one_done", nd == 1, 1'b1);
      check_bit("busy_start idle_after", busy, 1'b0);
   endtask

   task automatic test_reset_midflight();
      int d, nd;
      bit bok, hok, iok;
      launch(16'h5000, 16'h5001);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check_bit("midreset busy", busy, 1'b0);
      n_cmp++;
      if ({A_greater_B, A_less_B, A_equal_B} !== 3'b000) begin
         n_fail++;
         $display("FAIL midreset flags: got %b want 000", {A_greater_B, A_less_B, A_equal_B});
      end
      tick();
      reset = 1'b0;
      watch(4, 10, d, nd, bok, hok, iok);
      check_bit("midreset no_done", nd == 0, 1'b1);
      launch(16'h5000, 16'h5001);
      watch(1, 8, d, nd, bok, hok, iok);
      check_result("after_reset", d, 5, 3'b010);
   endtask

   task automatic test_back_to_back();
      int dc[$];
      A = 16'h0003;
      B = 16'h0003;
      start = 1'b1;
      tick();
      for (int c = 1; c <= 12; c++) begin
         if (done === 1'b1) dc.push_back(c);
         tick();
      end
      start = 1'b0;
      n_cmp++;
      if (dc.size() != 2 || dc[0] != 5 || dc[1] != 11) begin
         n_fail++;
         $display("FAIL back_to_back done_cycles: got %p want 5 and 11", dc);
      end
      n_cmp++;
      if ({A_greater_B, A_less_B, A_equal_B} !== 3'b001) begin
         n_fail++;
         $display("FAIL back_to_back flags: got %b want 001", {A_greater_B, A_less_B, A_equal_B});
      end
      repeat (8) tick();
   endtask

   initial begin
      test_reset();
      test_equal();
      test_greater();
      test_less_low_nibble();
      test_start_while_busy();
      test_reset_midflight();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
